// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: access-size encodings, memory-stage FSM states, default datapath width.
package cpu_pkg;

    localparam int DW_DEF = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational little-endian lane unit: store replication, byte enables, misalignment, load extract/extend.
module mem_lane_align
    import cpu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_rep,
    output logic [3:0]  byte_en,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte = rdata[7:0];
        case (addr_lo)
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            2'd3:    rd_byte = rdata[31:24];
            default: rd_byte = rdata[7:0];
        endcase
        rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Size 2'b11 falls through to the word case.
    always_comb begin
        wdata_rep  = wdata;
        byte_en    = 4'b1111;
        rdata_ext  = rdata;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                wdata_rep = {4{wdata[7:0]}};
                byte_en   = 4'b0001 << addr_lo;
                rdata_ext = {{24{~is_unsigned & rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                wdata_rep  = {2{wdata[15:0]}};
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                rdata_ext  = {{16{~is_unsigned & rd_half[15]}}, rd_half};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: drives the MIO bus for loads/stores, stalls upstream, feeds MEM/WB.
// Optional bus timeout abort enabled by defining MEM_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | evaluate EX/MEM slot; ALU results and misaligned faults pass straight to MEM/WB
// ACCESS | bus request held until MIO_ready (or timeout)
// DONE   | writeback slot valid with load data; upstream advances
module mem_stage
    import cpu_pkg::*;
#(
    parameter int DW             = DW_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic          ex_mem_read,
    input  logic          ex_mem_write,
    input  logic [1:0]    ex_size,
    input  logic          ex_unsigned,
    input  logic [DW-1:0] ex_alu_result,
    input  logic [DW-1:0] ex_wdata,
    input  logic [4:0]    ex_rd,
    input  logic          ex_reg_write,
    input  logic [DW-1:0] Data_in,
    input  logic          MIO_ready,
    output logic          CPU_MIO,
    output logic [DW-1:0] Addr_out,
    output logic [DW-1:0] Data_out,
    output logic          mem_w,
    output logic [3:0]    byte_en,
    output logic          mem_stall,
    output logic          wb_valid,
    output logic [DW-1:0] wb_data,
    output logic [4:0]    wb_rd,
    output logic          wb_reg_write,
    output logic          exc_misalign,
    output logic          exc_bus_timeout,
    output logic [DW-1:0] exc_addr,
    output logic [1:0]    dbg_state
);

    mem_state_e    state_q, state_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [4:0]    rd_q, rd_d;
    logic          regw_q, regw_d;
    logic          wb_valid_q, wb_valid_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic          wb_regw_q, wb_regw_d;
    logic          exc_mis_q, exc_mis_d;
    logic          exc_to_q, exc_to_d;
    logic [DW-1:0] exc_addr_q, exc_addr_d;
    logic          stall_c;

    logic          in_idle;
    logic [1:0]    la_addr;
    logic [1:0]    la_size;
    logic          la_uns;
    logic [31:0]   la_wrep;
    logic [3:0]    la_be;
    logic [31:0]   la_rext;
    logic          la_mis;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // IDLE decodes the incoming instruction; later states decode the registered access.
    assign in_idle = (state_q == ST_IDLE);
    assign la_addr = in_idle ? ex_alu_result[1:0] : addr_q[1:0];
    assign la_size = in_idle ? ex_size : size_q;
    assign la_uns  = in_idle ? ex_unsigned : uns_q;

    mem_lane_align u_lane (
        .addr_lo     (la_addr),
        .size        (la_size),
        .is_unsigned (la_uns),
        .wdata       (ex_wdata),
        .rdata       (Data_in),
        .wdata_rep   (la_wrep),
        .byte_en     (la_be),
        .rdata_ext   (la_rext),
        .misaligned  (la_mis)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stall_c    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        write_d    = write_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rd_d       = rd_q;
        regw_d     = regw_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_regw_d  = 1'b0;
        exc_mis_d  = 1'b0;
        exc_to_d   = 1'b0;
        exc_addr_d = exc_addr_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (!(ex_mem_read || ex_mem_write)) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_alu_result;
                        wb_rd_d    = ex_rd;
                        wb_regw_d  = ex_reg_write;
                    end else if (la_mis) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_alu_result;
                        wb_rd_d    = ex_rd;
                        exc_mis_d  = 1'b1;
                        exc_addr_d = ex_alu_result;
                    end else begin
                        stall_c = 1'b1;
                        addr_d  = ex_alu_result;
                        wdata_d = la_wrep;
                        be_d    = la_be;
                        write_d = ex_mem_write;
                        size_d  = ex_size;
                        uns_d   = ex_unsigned;
                        rd_d    = ex_rd;
                        regw_d  = ex_reg_write;
                        state_d = ST_ACCESS;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ST_ACCESS: begin
                stall_c = 1'b1;
                if (MIO_ready) begin
                    state_d    = ST_DONE;
                    wb_valid_d = 1'b1;
                    wb_data_d  = la_rext;
                    wb_rd_d    = rd_q;
                    wb_regw_d  = regw_q & ~write_q;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = ST_DONE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    exc_to_d   = 1'b1;
                    exc_addr_d = addr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            write_q    <= 1'b0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            regw_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_regw_q  <= 1'b0;
            exc_mis_q  <= 1'b0;
            exc_to_q   <= 1'b0;
            exc_addr_q <= '0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            write_q    <= write_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            regw_q     <= regw_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_regw_q  <= wb_regw_d;
            exc_mis_q  <= exc_mis_d;
            exc_to_q   <= exc_to_d;
            exc_addr_q <= exc_addr_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Stall is combinational from the EX/MEM inputs, so it is masked while in reset.
    assign mem_stall       = stall_c & rst;
    assign CPU_MIO         = (state_q == ST_ACCESS);
    assign mem_w           = CPU_MIO & write_q;
    assign Addr_out        = {addr_q[DW-1:2], 2'b00};
    assign Data_out        = wdata_q;
    assign byte_en         = be_q;
    assign wb_valid        = wb_valid_q;
    assign wb_data         = wb_data_q;
    assign wb_rd           = wb_rd_q;
    assign wb_reg_write    = wb_regw_q;
    assign exc_misalign    = exc_mis_q;
    assign exc_bus_timeout = exc_to_q;
    assign exc_addr        = exc_addr_q;
    assign dbg_state       = state_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipelined CPU. It sits between the EX/MEM register (upstream) and the MEM/WB register (downstream).
- Drives the CPU-to-MIO bus for loads and stores, holds the pipeline while the bus completes, and presents aligned, extended load data (or the ALU result) to writeback.
- Detects misaligned accesses, which cause no bus cycle.

Parameters:
- DW, 32, data/address width.
- TIMEOUT_CYCLES, 255, bus cycles waited for MIO_ready before abort (only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX/MEM slot holds an instruction.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store (mem_read and mem_write are never both 1).
- ex_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- ex_unsigned  in  1  zero-extend loads.
- ex_alu_result  in  DW  address, or the writeback value for non-memory instructions.
- ex_wdata  in  DW  store data, right-justified.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  writeback enable.
- Data_in  in  DW  bus read data.
- MIO_ready  in  1  bus completes the access this cycle.
- CPU_MIO  out  1  bus request.
- Addr_out  out  DW  word-aligned address ({addr[31:2],2'b00}).
- Data_out  out  DW  store data replicated to the addressed lane.
- mem_w  out  1  write strobe.
- byte_en  out  4  lane enables.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- wb_valid  out  1  MEM/WB slot valid.
- wb_data  out  DW  writeback value.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  writeback enable.
- exc_misalign  out  1  one-cycle pulse.
- exc_bus_timeout  out  1  one-cycle pulse.
- exc_addr  out  DW  faulting address.
- dbg_state  out  2  FSM state.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE. Every output is 0: CPU_MIO, mem_w, byte_en, Addr_out, Data_out, wb_*, exc_*, exc_addr, mem_stall.
- Reset during ACCESS drops CPU_MIO immediately. Reset has priority over every other event.
- Lane mapping is little-endian: byte at addr[1:0]=n occupies bits 8n+7:8n. Halfword at addr[1]=h occupies bits 16h+15:16h.
- Alignment:
  - Half with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - Byte accesses are always aligned.
- FSM states: IDLE=0, ACCESS=1, DONE=2.
- IDLE, ex_valid=1 with no memory op:
  - Next edge: wb_valid=1, wb_data=ex_alu_result, wb_rd/wb_reg_write copied.
  - No stall; throughput 1 per cycle.
- IDLE, aligned load or store:
  - mem_stall=1 combinationally.
  - Next edge: register address, byte_en, lane-replicated data and access type; enter ACCESS. wb_valid=0 (bubble).
- IDLE, misaligned access:
  - No bus cycle; mem_stall=0.
  - Next edge: wb_valid=1, wb_reg_write=0, exc_misalign=1 for one cycle, exc_addr=ex_alu_result.
- ACCESS:
  - CPU_MIO=1, mem_w=store, mem_stall=1.
  - Addr_out, Data_out and byte_en stay stable until completion.
  - On an edge where MIO_ready=1, capture Data_in and enter DONE. CPU_MIO drops the next cycle.
  - MIO_ready in IDLE or DONE is ignored.
- DONE:
  - wb_valid=1. Load: wb_data is the extracted lane, sign- or zero-extended. Store: wb_reg_write=0.
  - mem_stall=0, so upstream advances on this edge. Next state IDLE.
  - The new EX/MEM instruction is evaluated in IDLE on the following cycle.
- Minimum memory latency: 3 cycles (IDLE, ACCESS, DONE) when MIO_ready is asserted in the first ACCESS cycle.
- wb_valid=0 in every cycle not listed above.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on ACCESS entry and increments each ACCESS cycle without MIO_ready.
  - At TIMEOUT_CYCLES: abort (CPU_MIO drops next cycle), pulse exc_bus_timeout, load exc_addr, enter DONE with wb_reg_write=0.
  - MIO_ready on the same edge as expiry wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely; exc_bus_timeout tied to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state constants;
  - the DW default.
- One natural sub-module, mem_lane_align: a combinational store-replicate, byte_en generation, and load extract/extend unit. It is reusable by the cache path.

Test Plan:
- ALU pass-through: add with result 0x0000_1234, rd=5 → next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, mem_stall never 1.
- Signed byte load: addr 0x103, Data_in=0x80FF_0000, MIO_ready on the first ACCESS cycle → Addr_out=0x100, byte_en=1000, wb_data=0xFFFF_FF80 in DONE, total 3 cycles.
- Half store with 4 wait states: addr 0x202, wdata 0xABCD → Data_out=0xABCD_ABCD, byte_en=1100, mem_w=1, stall held 5 ACCESS cycles, wb_reg_write=0.
- Misaligned word load: addr 0x301 → no CPU_MIO, exc_misalign pulse, exc_addr=0x301, wb_reg_write=0.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and MIO_ready held low → exc_bus_timeout after 4 ACCESS cycles, FSM returns IDLE.
- Reset asserted mid-ACCESS → CPU_MIO=0 immediately; after release, pipeline resumes cleanly from IDLE.
